// File: rtl/dice_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dice_pkg
// Purpose  : Shared helpers for the DICE RAM arbiter slice.
//            idx_width() gives the width of a requester index,
//            clamped to at least one bit so that N=1 still has a
//            legal index type.
// Revision : 1.0 - initial release
// ============================================================================
package dice_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dice_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : dice_rr_arb
// Purpose  : Round-robin arbiter. The first requester at or after the
//            internal pointer (mod N) wins. The pointer moves to winner+1
//            when en is high and some request is present.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            req[N]          - request vector
//            en              - allow grant to advance the pointer
//            grant[N]        - one-hot grant (zero when no request)
//            grant_idx       - binary index of the winner
// Revision : 1.0 - initial release
// ============================================================================
module dice_rr_arb
    import dice_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = idx_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx
);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;
    logic            w_found;

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!w_found && req[IDXW'(j)]) begin
                w_found             = 1'b1;
                grant[IDXW'(j)]     = 1'b1;
                grant_idx           = IDXW'(j);
            end
        end

        ptr_d = ptr_q;
        if (en && w_found) begin
            ptr_d = (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dice_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : dice_ram_arb
// Purpose  : Shares one 1W/1R DICE RAM between NUM_REQS requesters. Writes
//            and reads are round-robin arbitrated independently. A single
//            in-flight read slot routes the registered RAM data back to the
//            issuing requester; when that requester does not accept, the
//            RAM read port is stalled so its output holds.
// Ports    : clk, reset                      - clock, sync active-high reset
//            wr_req_valid/ready/addr/data    - write request channel
//            rd_req_valid/ready/addr         - read request channel
//            rd_rsp_valid/ready/data         - read response channel
//            ram_wr_en/addr/data             - RAM write port
//            ram_rd_en/addr, ram_rd_data     - RAM read port
// Revision : 1.0 - initial release
// ============================================================================
module dice_ram_arb
    import dice_pkg::*;
#(
    parameter int NUM_REQS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            wr_req_valid,
    output logic [NUM_REQS-1:0]            wr_req_ready,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] wr_req_data,
    input  logic [NUM_REQS-1:0]            rd_req_valid,
    output logic [NUM_REQS-1:0]            rd_req_ready,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0] rd_req_addr,
    output logic [NUM_REQS-1:0]            rd_rsp_valid,
    input  logic [NUM_REQS-1:0]            rd_rsp_ready,
    output logic [DATA_WIDTH-1:0]          rd_rsp_data,
    output logic                           ram_wr_en,
    output logic [ADDR_WIDTH-1:0]          ram_wr_addr,
    output logic [DATA_WIDTH-1:0]          ram_wr_data,
    output logic                           ram_rd_en,
    output logic [ADDR_WIDTH-1:0]          ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]          ram_rd_data
);

    localparam int OWNW = idx_width(NUM_REQS);

    logic [NUM_REQS-1:0] w_wr_grant;
    logic [OWNW-1:0]     w_wr_idx;
    logic [NUM_REQS-1:0] w_rd_grant;
    logic [OWNW-1:0]     w_rd_idx;
    logic                w_can_issue;
    logic                w_rd_issue;

    logic                rsp_vld_q;
    logic [OWNW-1:0]     rsp_owner_q;

    // A new read may issue only if the slot is empty or drains this cycle.
    assign w_can_issue = !rsp_vld_q || rd_rsp_ready[rsp_owner_q];
    assign w_rd_issue  = w_can_issue && (|rd_req_valid) && !reset;

    dice_rr_arb #(
        .N    (NUM_REQS),
        .IDXW (OWNW)
    ) u_wr_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (wr_req_valid),
        .en        (1'b1),
        .grant     (w_wr_grant),
        .grant_idx (w_wr_idx)
    );

    dice_rr_arb #(
        .N    (NUM_REQS),
        .IDXW (OWNW)
    ) u_rd_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (rd_req_valid),
        .en        (w_can_issue),
        .grant     (w_rd_grant),
        .grant_idx (w_rd_idx)
    );

    // Write port
    assign wr_req_ready = reset ? '0 : w_wr_grant;
    assign ram_wr_en    = !reset && (|wr_req_valid);
    assign ram_wr_addr  = wr_req_addr[w_wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign ram_wr_data  = wr_req_data[w_wr_idx*DATA_WIDTH +: DATA_WIDTH];

    // Read issue; a stall leaves ram_rd_en low so the RAM output holds.
    assign rd_req_ready = (w_can_issue && !reset) ? w_rd_grant : '0;
    assign ram_rd_en    = w_rd_issue;
    assign ram_rd_addr  = rd_req_addr[w_rd_idx*ADDR_WIDTH +: ADDR_WIDTH];

    // Response routing
    always_comb begin
        rd_rsp_valid = '0;
        if (rsp_vld_q && !reset) begin
            rd_rsp_valid[rsp_owner_q] = 1'b1;
        end
    end
    assign rd_rsp_data = ram_rd_data;

    // In-flight slot: reloaded whenever issue is allowed, else held.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld_q   <= 1'b0;
            rsp_owner_q <= '0;
        end else if (w_can_issue) begin
            rsp_vld_q <= |rd_req_valid;
            if (|rd_req_valid) begin
                rsp_owner_q <= w_rd_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dice_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dice_ram_arb
// Purpose  : Self-checking bench for dice_ram_arb with a behavioural RAM
//            and a queue-based reference model of grants and responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dice_ram_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    wr_req_valid, wr_req_ready;
    logic [N*AW-1:0] wr_req_addr;
    logic [N*DW-1:0] wr_req_data;
    logic [N-1:0]    rd_req_valid, rd_req_ready;
    logic [N*AW-1:0] rd_req_addr;
    logic [N-1:0]    rd_rsp_valid, rd_rsp_ready;
    logic [DW-1:0]   rd_rsp_data;
    logic            ram_wr_en, ram_rd_en;
    logic [AW-1:0]   ram_wr_addr, ram_rd_addr;
    logic [DW-1:0]   ram_wr_data;
    logic [DW-1:0]   ram_rd_data = '0;

    dice_ram_arb #(
        .NUM_REQS   (N),
        .DATA_WIDTH (DW),
        .DEPTH      (1024),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data  (rd_rsp_data),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural 1W/1R RAM: registered read, read-before-write, holds
    // output while ram_rd_en is low. Unwritten words read as zero.
    logic [DW-1:0] ram_mem [int];
    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_rd_data <= ram_mem.exists(int'(ram_rd_addr)) ? ram_mem[int'(ram_rd_addr)] : '0;
        end
        if (ram_wr_en) begin
            ram_mem[int'(ram_wr_addr)] = ram_wr_data;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            owner;
        logic [DW-1:0] data;
    } rsp_t;

    int            m_wr_ptr = 0;
    int            m_rd_ptr = 0;
    rsp_t          m_q[$];
    logic [DW-1:0] shadow [int];

    int            last_wr_grant, last_rd_grant;
    logic [N-1:0]  s_rsp_valid, s_wr_ready, s_rd_ready;
    logic [DW-1:0] s_rsp_data;
    logic          s_ram_rd_en;

    function automatic int rr(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] one;
        one = 1;
        return (i < 0) ? '0 : (one << i);
    endfunction

    function automatic logic [DW-1:0] shadow_rd(input int a);
        return shadow.exists(a) ? shadow[a] : '0;
    endfunction

    // One clock cycle: inputs are already driven; compare at the falling
    // edge, advance the model, then return just after the rising edge.
    task automatic step();
        int   ww, rw, a;
        bit   can;
        rsp_t r;
        @(negedge clk);
        s_rsp_valid   = rd_rsp_valid;
        s_rsp_data    = rd_rsp_data;
        s_wr_ready    = wr_req_ready;
        s_rd_ready    = rd_req_ready;
        s_ram_rd_en   = ram_rd_en;
        last_wr_grant = -1;
        last_rd_grant = -1;
        if (reset) begin
            chk("rst_wr_ready", wr_req_ready, 0);
            chk("rst_rd_ready", rd_req_ready, 0);
            chk("rst_ram_wr_en", ram_wr_en, 0);
            chk("rst_ram_rd_en", ram_rd_en, 0);
            chk("rst_rsp_valid", rd_rsp_valid, 0);
            m_wr_ptr = 0;
            m_rd_ptr = 0;
            m_q.delete();
        end else begin
            ww = rr(wr_req_valid, m_wr_ptr);
            chk("wr_req_ready", wr_req_ready, oh(ww));
            chk("ram_wr_en", ram_wr_en, ww >= 0);
            if (ww >= 0) begin
                chk("ram_wr_addr", ram_wr_addr, wr_req_addr[ww*AW +: AW]);
                chk("ram_wr_data", ram_wr_data, wr_req_data[ww*DW +: DW]);
            end
            can = (m_q.size() == 0) || rd_rsp_ready[m_q[0].owner];
            chk("rd_rsp_valid", rd_rsp_valid, (m_q.size() != 0) ? oh(m_q[0].owner) : '0);
            if (m_q.size() != 0) begin
                chk("rd_rsp_data", rd_rsp_data, m_q[0].data);
            end
            rw = can ? rr(rd_req_valid, m_rd_ptr) : -1;
            chk("rd_req_ready", rd_req_ready, oh(rw));
            chk("ram_rd_en", ram_rd_en, rw >= 0);
            if (rw >= 0) begin
                chk("ram_rd_addr", ram_rd_addr, rd_req_addr[rw*AW +: AW]);
            end
            // Advance: deliver, then issue (old data), then write.
            if (m_q.size() != 0 && rd_rsp_ready[m_q[0].owner]) begin
                void'(m_q.pop_front());
            end
            if (rw >= 0) begin
                a       = int'(rd_req_addr[rw*AW +: AW]);
                r.owner = rw;
                r.data  = shadow_rd(a);
                m_q.push_back(r);
                m_rd_ptr      = (rw + 1) % N;
                last_rd_grant = rw;
            end
            if (ww >= 0) begin
                shadow[int'(wr_req_addr[ww*AW +: AW])] = wr_req_data[ww*DW +: DW];
                m_wr_ptr      = (ww + 1) % N;
                last_wr_grant = ww;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_req_valid = '0;
        rd_req_valid = '0;
        rd_rsp_ready = '1;
    endtask

    task automatic set_wr(input int i, input int a, input logic [DW-1:0] d);
        wr_req_valid[i]        = 1'b1;
        wr_req_addr[i*AW +: AW] = AW'(a);
        wr_req_data[i*DW +: DW] = d;
    endtask

    task automatic set_rd(input int i, input int a);
        rd_req_valid[i]        = 1'b1;
        rd_req_addr[i*AW +: AW] = AW'(a);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [N-1:0] val;
        logic [N-1:0] exp_rdy;
    } wvec_t;

    wvec_t         tbl [16];
    logic [DW-1:0] got [$];
    bit            wp [N];
    bit            rp [N];
    int            k;

    initial begin
        // Fairness (8 x all valid), wrap between 3 and 0, hold, skip-scan.
        for (int v = 0; v < 8; v++) tbl[v] = '{4'b1111, oh(v % 4)};
        tbl[8]  = '{4'b1001, 4'b0001};
        tbl[9]  = '{4'b1001, 4'b1000};
        tbl[10] = '{4'b1001, 4'b0001};
        tbl[11] = '{4'b1001, 4'b1000};
        tbl[12] = '{4'b0000, 4'b0000};
        tbl[13] = '{4'b0100, 4'b0100};
        tbl[14] = '{4'b0011, 4'b0001};
        tbl[15] = '{4'b0011, 4'b0010};

        wr_req_addr = '0;
        wr_req_data = '0;
        rd_req_addr = '0;
        idle();
        reset        = 1'b1;
        wr_req_valid = '1;
        rd_req_valid = '1;
        #1;
        step();
        step();
        reset = 1'b0;
        idle();

        // Table-driven write arbitration
        for (int v = 0; v < 16; v++) begin
            for (int i = 0; i < N; i++) begin
                wr_req_addr[i*AW +: AW] = AW'(64 + 16 * i + v);
                wr_req_data[i*DW +: DW] = 32'hA000_0000 | DW'(v << 4) | DW'(i);
            end
            wr_req_valid = tbl[v].val;
            step();
            chk("tbl_wr_ready", s_wr_ready, tbl[v].exp_rdy);
        end
        idle();

        // Write then read
        set_wr(0, 5, 32'hDEADBEEF);
        step();
        chk("wtr_wr_ready", s_wr_ready, 4'b0001);
        idle();
        set_rd(2, 5);
        step();
        chk("wtr_rd_ready", s_rd_ready, 4'b0100);
        idle();
        step();
        chk("wtr_rsp_valid", s_rsp_valid, 4'b0100);
        chk("wtr_rsp_data", s_rsp_data, 32'hDEADBEEF);

        // Read backpressure: req1 reads 0..3, stalls 3 cycles at 2nd response
        for (int j = 0; j < 4; j++) begin
            idle();
            set_wr(3, j, 32'h100 + j);
            step();
        end
        idle();
        k = 0;
        for (int c = 0; c < 10; c++) begin
            rd_req_valid = '0;
            if (k < 4) set_rd(1, k);
            rd_rsp_ready = (c >= 2 && c <= 4) ? 4'b1101 : 4'b1111;
            step();
            if (last_rd_grant == 1) k++;
            if (s_rsp_valid[1] && rd_rsp_ready[1]) got.push_back(s_rsp_data);
            if (c >= 2 && c <= 4) begin
                chk("bp_held_data", s_rsp_data, 32'h101);
                chk("bp_no_rd_en", s_ram_rd_en, 0);
                chk("bp_no_ready", s_rd_ready, 0);
            end
        end
        chk("bp_count", got.size(), 4);
        for (int j = 0; j < 4 && j < got.size(); j++) chk("bp_order", got[j], 32'h100 + j);
        idle();

        // Same-address collision
        set_wr(0, 7, 32'h11);
        step();
        idle();
        set_wr(0, 7, 32'h22);
        set_rd(0, 7);
        step();
        idle();
        step();
        chk("col_old_valid", s_rsp_valid, 4'b0001);
        chk("col_old_data", s_rsp_data, 32'h11);
        set_rd(0, 7);
        step();
        idle();
        step();
        chk("col_new_data", s_rsp_data, 32'h22);

        // Reset while a response is pending
        set_rd(3, 3);
        step();
        idle();
        reset        = 1'b1;
        wr_req_valid = '1;
        rd_req_valid = '1;
        step();
        reset = 1'b0;
        step();
        chk("rst_next_rsp_valid", s_rsp_valid, 4'b0000);
        chk("rst_next_wr_ready", s_wr_ready, 4'b0001);
        chk("rst_next_rd_ready", s_rd_ready, 4'b0001);
        idle();
        step();
        step();

        // Randomised traffic with protocol-compliant requesters
        for (int i = 0; i < N; i++) begin
            wp[i] = 0;
            rp[i] = 0;
        end
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!wp[i] && ($urandom_range(0, 2) == 0)) begin
                    wp[i] = 1;
                    set_wr(i, $urandom_range(0, 15), $urandom);
                end
                if (!rp[i] && ($urandom_range(0, 2) == 0)) begin
                    rp[i] = 1;
                    set_rd(i, $urandom_range(0, 15));
                end
                wr_req_valid[i] = wp[i];
                rd_req_valid[i] = rp[i];
                rd_rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            reset = ($urandom_range(0, 199) == 0);
            step();
            if (last_wr_grant >= 0) wp[last_wr_grant] = 0;
            if (last_rd_grant >= 0) rp[last_rd_grant] = 0;
        end
        reset = 1'b0;
        idle();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
